// File: rtl/mips_mem_pkg.sv
`default_nettype none
// =====================================================================
// mips_mem_pkg: shared op/state encodings and helpers for the MEM stage
// Revision: 1.0 - initial release
// =====================================================================
package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int c_dmem_words = 64;

    function automatic logic is_load(input op_e op);
        return (op <= OP_LBU);
    endfunction

    function automatic logic is_sub_word(input op_e op);
        return !((op == OP_LW) || (op == OP_SW));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// =====================================================================
// lsu_align: extracts/extends sub-word loads and merges sub-word stores
// Revision: 1.0 - initial release
// =====================================================================
module lsu_align
    import mips_mem_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select: offset 0 is the least significant byte.
    assign w_byte = word_i[{off_i, 3'b000} +: 8];
    assign w_half = off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        ld_data_o = 32'h0;
        st_word_o = word_i;
        case (op_i)
            OP_LW:   ld_data_o = word_i;
            OP_LH:   ld_data_o = {{16{w_half[15]}}, w_half};
            OP_LHU:  ld_data_o = {16'h0, w_half};
            OP_LB:   ld_data_o = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  ld_data_o = {24'h0, w_byte};
            OP_SW:   st_word_o = wdata_i;
            OP_SH:   st_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            OP_SB:   st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// =====================================================================
// mem_access_unit: MEM-stage load/store FSM driving a word-only bank
// Revision: 1.0 - initial release
// =====================================================================
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DMEM_WORDS = c_dmem_words,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata
);

    state_e              state_q;
    op_e                 op_q;
    logic [1:0]          off_q;
    logic [31:0]         wdata_q;
    logic                memread_q;
    logic                memwrite_q;
    logic [ADDR_W-1:0]   address_q;
    logic [31:0]         writedata_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_fault_q;

    op_e         w_req_op;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_word;

    assign w_req_op = op_e'(req_op);
    assign w_misaligned =
        (((w_req_op == OP_LW) || (w_req_op == OP_SW)) && (req_addr[1:0] != 2'b00)) ||
        (((w_req_op == OP_LH) || (w_req_op == OP_LHU) || (w_req_op == OP_SH)) && req_addr[0]);
    assign w_out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DMEM_WORDS));

    // Bank read data feeds the aligner directly; results are captured on the RD edge.
    lsu_align u_align (
        .op_i      (op_q),
        .off_i     (off_q),
        .word_i    (readdata),
        .wdata_i   (wdata_q),
        .ld_data_o (w_ld_data),
        .st_word_o (w_st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LW;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            address_q    <= '0;
            writedata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= w_req_op;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (w_misaligned || w_out_of_range) begin
                            resp_rdata_q <= 32'h0;
                            resp_fault_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (w_req_op == OP_SW) begin
                            address_q   <= req_addr[ADDR_W+1:2];
                            writedata_q <= req_wdata;
                            memwrite_q  <= 1'b1;
                            state_q     <= S_WR;
                        end else begin
                            address_q <= req_addr[ADDR_W+1:2];
                            memread_q <= 1'b1;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    memread_q <= 1'b0;
                    if (is_load(op_q)) begin
                        resp_rdata_q <= w_ld_data;
                        resp_fault_q <= 1'b0;
                        state_q      <= S_RESP;
                    end else begin
                        writedata_q <= w_st_word;
                        memwrite_q  <= 1'b1;
                        state_q     <= S_WR;
                    end
                end
                S_WR: begin
                    memwrite_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_fault_q <= 1'b0;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign address    = address_q;
    assign writedata  = writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// =====================================================================
// tb_mem_access_unit: directed self-checking bench with a word bank model
// Revision: 1.0 - initial release
// =====================================================================
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        memread;
    logic        memwrite;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    logic [31:0] mem [0:63];
    int          n_vec;
    int          n_err;
    int          rd_cnt;
    int          wr_cnt;
    int          both_cnt;
    logic [7:0]  rd_addr;

    mem_access_unit #(.DMEM_WORDS(64), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .memread    (memread),
        .memwrite   (memwrite),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign readdata = (memread && address < 8'd64) ? mem[address[5:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (memwrite && address < 8'd64) mem[address[5:0]] <= writedata;
    end

    always @(negedge clk) begin
        if (memread) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = address;
        end
        if (memwrite) wr_cnt = wr_cnt + 1;
        if (memread && memwrite) both_cnt = both_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and measure edges from acceptance to resp_valid.
    task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic flt);
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk);
        check_val("req_ready_before", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        if (!resp_valid) check_val("resp_timeout", 32'd0, 32'd1);
        rd  = resp_rdata;
        flt = resp_fault;
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        flt;
    logic [31:0] held_rd;
    logic        held_flt;

    initial begin
        n_vec = 0; n_err = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; rd_addr = 8'h0;
        for (int i = 0; i < 64; i++) mem[i] = i * 10;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
        req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check_val("rst_outs", {26'h0, resp_valid, resp_fault, memread, memwrite, 2'b00}, 32'd0);
        check_val("rst_rdata", resp_rdata, 32'h0);
        check_val("rst_address", {24'h0, address}, 32'h0);
        check_val("rst_writedata", writedata, 32'h0);
        rst_n = 1'b1;

        issue(OP_LW, 32'h28, 32'h0, lat, rd, flt);
        check_val("lw_lat", lat, 2);
        check_val("lw_rdata", rd, 32'd100);
        check_val("lw_fault", {31'h0, flt}, 32'd0);
        check_val("lw_rd_pulses", rd_cnt, 1);
        check_val("lw_rd_addr", {24'h0, rd_addr}, 32'd10);
        check_val("lw_wr_pulses", wr_cnt, 0);

        issue(OP_SB, 32'h29, 32'hFF, lat, rd, flt);
        check_val("sb_lat", lat, 3);
        check_val("sb_rdata", rd, 32'h0);
        check_val("sb_pulses", {rd_cnt[15:0], wr_cnt[15:0]}, 32'h0001_0001);
        check_val("sb_mem10", mem[10], 32'h0000FF64);
        issue(OP_LB, 32'h29, 32'h0, lat, rd, flt);
        check_val("lb_rdata", rd, 32'hFFFFFFFF);
        issue(OP_LBU, 32'h29, 32'h0, lat, rd, flt);
        check_val("lbu_rdata", rd, 32'h000000FF);

        issue(OP_SH, 32'h2E, 32'h8001, lat, rd, flt);
        check_val("sh_lat", lat, 3);
        check_val("sh_mem11", mem[11], 32'h8001006E);
        issue(OP_LH, 32'h2E, 32'h0, lat, rd, flt);
        check_val("lh_rdata", rd, 32'hFFFF8001);
        check_val("lh_lat", lat, 2);
        issue(OP_LHU, 32'h2E, 32'h0, lat, rd, flt);
        check_val("lhu_rdata", rd, 32'h00008001);

        issue(OP_LW, 32'h2A, 32'h0, lat, rd, flt);
        check_val("mis_lat", lat, 1);
        check_val("mis_fault", {31'h0, flt}, 32'd1);
        check_val("mis_rdata", rd, 32'h0);
        check_val("mis_strobes", rd_cnt + wr_cnt, 0);
        issue(OP_SW, 32'h100, 32'hCAFEF00D, lat, rd, flt);
        check_val("oor_lat", lat, 1);
        check_val("oor_fault", {31'h0, flt}, 32'd1);
        check_val("oor_rdata", rd, 32'h0);
        check_val("oor_strobes", rd_cnt + wr_cnt, 0);
        check_val("oor_mem0", mem[0], 32'd0);
        check_val("oor_mem63", mem[63], 32'd630);

        resp_ready = 1'b0;
        issue(OP_SW, 32'h14, 32'h12345678, lat, rd, flt);
        check_val("sw_lat", lat, 2);
        check_val("sw_mem5", mem[5], 32'h12345678);
        held_rd  = rd;
        held_flt = flt;
        rd_cnt = 0;
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b1;
                req_op    = OP_LW;
                req_addr  = 32'h28;
            end
            check_val("hold_valid", {31'h0, resp_valid}, 32'd1);
            check_val("hold_rdata", resp_rdata, held_rd);
            check_val("hold_fault", {31'h0, resp_fault}, {31'h0, held_flt});
            check_val("hold_req_ready", {31'h0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("hold_ignored", rd_cnt + wr_cnt, 0);
        check_val("hold_release_ready", {31'h0, req_ready}, 32'd1);

        // Reset during the write cycle of a read-modify-write.
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h0C; req_wdata = 32'hAB;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("rmw_wr_strobe", {31'h0, memwrite}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_memwrite", {31'h0, memwrite}, 32'd0);
        check_val("arst_outs", {26'h0, req_ready, resp_valid, resp_fault, memread, 2'b00}, 32'h20);
        check_val("arst_addr_wd", {address, writedata[23:0]}, 32'h0);
        check_val("arst_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("arst_mem3", mem[3], 32'd30);

        issue(OP_LW, 32'h28, 32'h0, lat, rd, flt);
        check_val("post_rst_lat", lat, 2);
        check_val("post_rst_rdata", rd, 32'h0000FF64);
        check_val("post_rst_fault", {31'h0, flt}, 32'd0);

        check_val("strobe_exclusive", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the MEM stage of the MIPS pipeline, directly upstream of the word-only data memory bank. Accepts one load or store request at a time from the pipeline, checks alignment and range, and drives the bank's memread/memwrite/address/writedata strobes. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as a read-modify-write, because the bank only writes whole words.

## Interface
Parameters:
- DMEM_WORDS, 64: number of 32-bit words in the data memory bank; word index must be < DMEM_WORDS.
- ADDR_W, 8: width of the bank's word address port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  32  load result, extended; 0 for stores and faults.
- resp_fault  out  1  request was misaligned or out of range; no memory access was made.
- memread  out  1  read strobe to the bank.
- memwrite  out  1  write strobe to the bank.
- address  out  ADDR_W  word address to the bank.
- writedata  out  32  word written to the bank.
- readdata  in  32  bank read data, combinationally valid while memread is high.

## Operation
- Request is accepted when req_valid && req_ready. The unit registers op, word index (req_addr[ADDR_W+1:2]), byte offset (req_addr[1:0]) and wdata.
- Fault checks are made at acceptance:
  - Misaligned: a word op with addr[1:0]!=0, or a half op with addr[0]!=0.
  - Out of range: addr[31:2] >= DMEM_WORDS.
  - A faulting request goes straight to RESP with resp_fault=1 and resp_rdata=0.
- States and transitions:
  - IDLE -> RD (any load, SH, SB), WR (SW) or RESP (fault).
  - RD: memread=1. readdata is captured at the clock edge. Loads go to RESP; SH/SB go to WR.
  - WR: memwrite=1 for exactly one cycle, with writedata = req_wdata (SW) or the captured word with the addressed byte/half replaced (SH/SB). Then RESP.
  - RESP: resp_valid=1, held with data stable until resp_ready. RESP -> IDLE on resp_valid && resp_ready.
- Byte order is little-endian: offset 0 is bits 7:0, and half offset 2 is bits 31:16.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- memread and memwrite are never high together. address and writedata are held stable for the whole strobe cycle. Both strobes are 0 in IDLE and RESP.
- A new request is never accepted while in RESP, even if resp_ready is high; req_ready rises the cycle after RESP exits.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, memread=0, memwrite=0, address=0, writedata=0.
- Latency from the accept edge to resp_valid:
  - LW/LH/LHU/LB/LBU: 2 cycles.
  - SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Fault: 1 cycle.
- Throughput: at most one request per (latency+1) cycles with resp_ready held high.
- Reset asserted mid-operation (including during a WR cycle) returns to IDLE immediately and drops memwrite asynchronously. A partially issued RMW is abandoned; the bank word keeps whatever the bank latched.

## Structure
- Shared package mips_mem_pkg holds:
  - the op encoding enum (LW…SB);
  - the state enum (IDLE, RD, WR, RESP);
  - the DMEM_WORDS default;
  - helper functions is_load and is_sub_word.
- Combinational sub-module lsu_align. Inputs: op, offset, memory word, store data. Outputs: the extended load result and the merged store word. The FSM and all registers stay in mem_access_unit.

## Test plan
- Bank model preloaded with word i = i*10 for all words. LW addr 0x28 -> resp after 2 cycles, rdata=100, fault=0, one memread pulse at word 10.
- SB addr 0x29, wdata 0xFF: RD then WR -> word 10 = 0x0000FF64. Then LB addr 0x29 -> 0xFFFFFFFF; LBU -> 0x000000FF.
- SH addr 0x2E, wdata 0x8001: word 11 = 0x8001006E. LH addr 0x2E -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x2A (misaligned) and SW addr 0x100 (word 64, out of range) -> resp after 1 cycle, fault=1, rdata=0, memread and memwrite never asserted, memory unchanged.
- resp_ready held low 5 cycles after SW 0x14 of 0x12345678: resp_valid, rdata and fault stay stable, req_ready stays low, and a new req_valid is ignored until the handshake completes. Word 5 = 0x12345678.
- rst_n pulsed low during the WR cycle of an SB: memwrite drops asynchronously, outputs go to reset values, and the next LW completes normally.
